// File: rtl/rr_arbiter_16.sv
// Sixteen-requester round-robin arbiter producing a registered one-hot grant
// with a valid/ready handshake and a saturating count of accepted grants.
module rr_arbiter_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        grant_ready,
    output logic [15:0] grant,
    output logic        grant_valid,
    output logic [15:0] grant_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  ptr;
    logic [3:0]  grant_idx;
    logic [3:0]  search_ptr;
    logic [3:0]  idx;
    logic [15:0] win_vec;
    logic        found;
    logic        accept;

    // The grant register is one-hot, so OR-ing indices is an exact encoder.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        grant_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (grant[i]) grant_idx = grant_idx | 4'(i);
        end
    end

    assign accept     = (state == GRANT) && grant_ready;
    // On accept the search restarts just past the winner, in the same edge.
    assign search_ptr = accept ? (grant_idx + 4'd1) : ptr;

    always_comb begin
        win_vec = 16'h0000;
        found   = 1'b0;
        idx     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = search_ptr + 4'(i);
            if (!found && req[idx]) begin
                win_vec[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign grant_valid = (state == GRANT);

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge and wins over a simultaneous accept.
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state       <= IDLE;
            grant       <= 16'h0000;
            ptr         <= 4'd0;
            grant_count <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= win_vec;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        ptr <= search_ptr;
                        if (grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
                        if (found) begin
                            grant <= win_vec;
                        end else begin
                            grant <= 16'h0000;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed self-checking bench for rr_arbiter_16: handshake, rotation, stall,
// wrap, reset override and count saturation, plus per-cycle grant invariants.
module tb_rr_arbiter_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        grant_ready;
    logic [15:0] grant;
    logic        grant_valid;
    logic [15:0] grant_count;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    rr_arbiter_16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant_ready (grant_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_count (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] enc(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i] !== 1'b0) r = r | (v[i] ? 4'(i) : 4'bxxxx);
        end
        return r;
    endfunction

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Invariants sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert ($countones(grant) <= 1 && ((grant == 16'h0) == !grant_valid)
                    && !(grant_valid && $isunknown(enc(grant)))) else begin
                errors++;
                $error("FAIL invariant observed grant=%h valid=%b expected onehot-or-zero matching valid",
                       grant, grant_valid);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req = 16'h0000;
        grant_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        check16("reset_grant", grant, 16'h0000);
        check1("reset_valid", grant_valid, 1'b0);
        check16("reset_count", grant_count, 16'h0000);

        // ready while idle is ignored
        grant_ready = 1'b1;
        step();
        check1("idle_ready_valid", grant_valid, 1'b0);
        check16("idle_ready_count", grant_count, 16'h0000);

        // single request, accepted at once
        req = 16'h0020;
        step();
        check16("single_grant", grant, 16'h0020);
        check1("single_valid", grant_valid, 1'b1);
        req = 16'h0000;
        step();
        check16("single_after_grant", grant, 16'h0000);
        check1("single_after_valid", grant_valid, 1'b0);
        check16("single_after_count", grant_count, 16'h0001);

        // full rotation, no bubbles, with wrap
        do_reset();
        req = 16'hFFFF;
        grant_ready = 1'b1;
        step();
        check16("rot_0", grant, 16'h0001);
        for (int i = 1; i < 16; i++) begin
            step();
            check16($sformatf("rot_%0d", i), grant, 16'h0001 << i);
        end
        step();
        check16("rot_wrap", grant, 16'h0001);
        check16("rot_count", grant_count, 16'd16);

        // accept at bit 15 wraps the pointer to 0
        req = 16'h8000;
        step();
        check16("wrap_g15", grant, 16'h8000);
        req = 16'h8001;
        step();
        check16("wrap_after15", grant, 16'h0001);

        // stall holds grant; req changes ignored
        do_reset();
        req = 16'h0101;
        grant_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check16("stall_hold", grant, 16'h0001);
        end
        req = 16'h0000;
        step();
        step();
        check16("stall_drop_grant", grant, 16'h0001);
        check1("stall_drop_valid", grant_valid, 1'b1);
        check16("stall_drop_count", grant_count, 16'h0000);
        req = 16'h0101;
        grant_ready = 1'b1;
        step();
        check16("stall_next", grant, 16'h0100);
        check16("stall_next_count", grant_count, 16'h0001);
        step();
        check16("stall_next2", grant, 16'h0001);
        check16("stall_next2_count", grant_count, 16'h0002);

        // reset overrides a simultaneous accept
        do_reset();
        req = 16'h0008;
        grant_ready = 1'b0;
        step();
        check16("rst_pre_grant", grant, 16'h0008);
        grant_ready = 1'b1;
        rst_n = 1'b0;
        step();
        check16("rst_acc_grant", grant, 16'h0000);
        check1("rst_acc_valid", grant_valid, 1'b0);
        check16("rst_acc_count", grant_count, 16'h0000);
        rst_n = 1'b1;
        req = 16'h0018;
        grant_ready = 1'b0;
        step();
        check16("rst_ptr0_grant", grant, 16'h0008);

        // saturation of the accepted-grant counter
        do_reset();
        req = 16'hFFFF;
        grant_ready = 1'b1;
        step();
        for (int i = 0; i < 65534; i++) step();
        check16("sat_fffe", grant_count, 16'hFFFE);
        step();
        check16("sat_ffff", grant_count, 16'hFFFF);
        step();
        check16("sat_hold", grant_count, 16'hFFFF);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
